// File: rtl/calc_sequenciador.sv
// ---------------------------------------------------------------------------
// calc_sequenciador
//   Initiator-side driver for the calculator datapath. Accepts one operation
//   request (opA, opB, op) on a start pulse while idle, then plays it into the
//   calculator as three Instrucao strobes (opA, opB, {00,op}) separated by
//   GAP_CYCLES idle cycles. It then waits up to TIMEOUT cycles for fim, and
//   either captures saida_regC (done pulse) or flags a timeout (erro pulse).
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : request pulse, only honoured in IDLE
//   opA, opB, op    : operands / ULA opcode, latched on an accepted start
//   fim, saida_regC : calculator result-valid flag and result register
//   Dados, Instrucao: value and step strobe presented to the calculator
//   busy            : high in every state except IDLE
//   done, erro      : one-cycle completion / timeout pulses
//   resultado       : last captured saida_regC
//   contagem        : completed-operation counter (wraps 255 -> 0)
//   state           : current FSM state, for debug
// ---------------------------------------------------------------------------
module calc_sequenciador #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] opA,
  input  logic [3:0] opB,
  input  logic [1:0] op,
  input  logic       fim,
  input  logic [4:0] saida_regC,
  output logic [3:0] Dados,
  output logic       Instrucao,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output logic [4:0] resultado,
  output logic [7:0] contagem,
  output logic [2:0] state
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    GAP_A    = 3'd2,
    LOAD_B   = 3'd3,
    GAP_B    = 3'd4,
    LOAD_OP  = 3'd5,
    WAIT_FIM = 3'd6
  } state_t;

  state_t      r_state;
  logic [3:0]  r_opb;
  logic [1:0]  r_op;
  logic [GW-1:0] r_gap;
  logic [TW-1:0] r_tmo;
  logic [3:0]  r_dados;
  logic        r_instr;
  logic        r_busy;
  logic        r_done;
  logic        r_erro;
  logic [4:0]  r_res;
  logic [7:0]  r_cnt;

  // Outputs are registered alongside the state, so each state's Dados /
  // Instrucao values are loaded on the edge that enters that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_opb   <= '0;
      r_op    <= '0;
      r_gap   <= '0;
      r_tmo   <= '0;
      r_dados <= '0;
      r_instr <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_erro  <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_erro <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // opA goes straight to Dados, so only opB/op need holding.
            r_opb   <= opB;
            r_op    <= op;
            r_dados <= opA;
            r_instr <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LOAD_A;
          end
        end
        LOAD_A: begin
          r_instr <= 1'b0;
          r_gap   <= '0;
          r_state <= GAP_A;
        end
        GAP_A: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) begin
            r_dados <= r_opb;
            r_instr <= 1'b1;
            r_state <= LOAD_B;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        LOAD_B: begin
          r_instr <= 1'b0;
          r_gap   <= '0;
          r_state <= GAP_B;
        end
        GAP_B: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) begin
            r_dados <= {2'b00, r_op};
            r_instr <= 1'b1;
            r_state <= LOAD_OP;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        LOAD_OP: begin
          r_instr <= 1'b0;
          r_tmo   <= '0;
          r_state <= WAIT_FIM;
        end
        WAIT_FIM: begin
          // fim is checked first so it wins over an expiring timeout.
          if (fim) begin
            r_res   <= saida_regC;
            r_done  <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_erro  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_instr <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Dados     = r_dados;
  assign Instrucao = r_instr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign erro      = r_erro;
  assign resultado = r_res;
  assign contagem  = r_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_calc_sequenciador.sv
module tb_calc_sequenciador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opA = '0, opB = '0;
  logic [1:0] op = '0;
  logic       fim = 1'b0;
  logic [4:0] saida_regC = '0;
  logic [3:0] Dados;
  logic       Instrucao, busy, done, erro;
  logic [4:0] resultado;
  logic [7:0] contagem;
  logic [2:0] state;

  calc_sequenciador #(.GAP_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB), .op(op),
    .fim(fim), .saida_regC(saida_regC), .Dados(Dados), .Instrucao(Instrucao),
    .busy(busy), .done(done), .erro(erro), .resultado(resultado),
    .contagem(contagem), .state(state)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Per-operation observations, cycle 1 = first cycle after start accepted.
  int r_insn, r_done, r_erro, r_end, r_bad;
  int r_ind[3];
  int r_inc[3];

  typedef struct {
    int a, b, o, d, res, hold, gfim;
    int e_done, e_erro, e_res, e_cnt, e_end;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // d   : calculator model raises fim d cycles after the LOAD_OP cycle (0=never)
  // hold: keep start high while busy (must be ignored)
  // gfim: stray fim with saida_regC=31 in that cycle (0=none)
  // tail: one extra idle cycle after completion, else return in the done cycle
  task automatic run_op(input int a, b, o, d, res, hold, gfim, tail);
    int n;
    int last;
    bit ended;
    r_insn = 0; r_done = 0; r_erro = 0; r_end = -1; r_bad = 0;
    for (int i = 0; i < 3; i++) begin r_ind[i] = -1; r_inc[i] = -1; end
    start = 1'b1; opA = 4'(a); opB = 4'(b); op = 2'(o); fim = 1'b0;
    n = 0; last = 0; ended = 0;
    while (!ended && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start = (hold != 0);
        // scramble inputs so only the latched copies can be used
        opA = ~4'(a); opB = ~4'(b); op = ~2'(o);
      end
      if (Instrucao) begin
        if (r_insn < 3) begin r_ind[r_insn] = int'(Dados); r_inc[r_insn] = n; end
        r_insn++;
        last = int'(Dados);
      end else if (r_insn > 0 && int'(Dados) != last) r_bad++;
      if (done) r_done++;
      if (erro) r_erro++;
      if (done || erro) begin
        ended = 1; r_end = n; start = 1'b0;
        if (busy) r_bad++;
      end else if (!busy) r_bad++;
      fim = (d > 0 && n == 7 + d) || (gfim > 0 && n == gfim);
      saida_regC = (gfim > 0 && n == gfim) ? 5'd31 : 5'(res);
    end
    if (!ended) begin
      nchk++; nerr++;
      $display("FAIL op_timeout: got no done/erro within 40 cycles expected completion");
      start = 1'b0;
    end
    if (tail != 0) begin
      @(posedge clk); #1;
      fim = 1'b0;
    end
  endtask

  vec_t vecs[7];
  int done_total;

  initial begin
    //            a  b  o  d  res hold gfim done erro res cnt end
    vecs[0] = '{ 5, 3, 0, 3,  8, 0, 0, 1, 0,  8, 1, 11};  // basic add
    vecs[1] = '{15,15, 0, 3, 30, 0, 0, 1, 0, 30, 2, 11};  // full 5-bit result
    vecs[2] = '{ 2, 1, 1, 0,  0, 0, 0, 0, 1, 30, 2, 24};  // timeout
    vecs[3] = '{ 7, 2, 1,16,  5, 0, 0, 1, 0,  5, 3, 24};  // fim on 16th wait cycle
    vecs[4] = '{ 1, 1, 2,17,  9, 0, 0, 0, 1,  5, 3, 24};  // fim one cycle late
    vecs[5] = '{12, 4, 3, 1, 16, 0, 2, 1, 0, 16, 4,  9};  // stray fim in GAP_A
    vecs[6] = '{ 6, 9, 2, 5, 15, 1, 0, 1, 0, 15, 5, 13};  // start held while busy

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({Dados, Instrucao, busy, done, erro, resultado, contagem}), 0);
    chk("reset_state", int'(state), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", int'({busy, Instrucao, state}), 0);

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].o, vecs[k].d, vecs[k].res,
             vecs[k].hold, vecs[k].gfim, 1);
      chk($sformatf("v%0d_ins_count", k), r_insn, 3);
      chk($sformatf("v%0d_dados_a", k), r_ind[0], vecs[k].a);
      chk($sformatf("v%0d_dados_b", k), r_ind[1], vecs[k].b);
      chk($sformatf("v%0d_dados_op", k), r_ind[2], vecs[k].o);
      chk($sformatf("v%0d_ins_cyc_a", k), r_inc[0], 1);
      chk($sformatf("v%0d_ins_cyc_b", k), r_inc[1], 4);
      chk($sformatf("v%0d_ins_cyc_op", k), r_inc[2], 7);
      chk($sformatf("v%0d_done", k), r_done, vecs[k].e_done);
      chk($sformatf("v%0d_erro", k), r_erro, vecs[k].e_erro);
      chk($sformatf("v%0d_end_cyc", k), r_end, vecs[k].e_end);
      chk($sformatf("v%0d_busy_hold", k), r_bad, 0);
      chk($sformatf("v%0d_resultado", k), int'(resultado), vecs[k].e_res);
      chk($sformatf("v%0d_contagem", k), int'(contagem), vecs[k].e_cnt);
      chk($sformatf("v%0d_idle_after", k), int'({done, erro, busy, state}), 0);
    end

    // async reset in the middle of LOAD_B
    start = 1'b1; opA = 4'd9; opB = 4'd6; op = 2'd2;
    repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    chk("midop_in_load_b", int'({Instrucao, Dados, state}), int'({1'b1, 4'd6, 3'd3}));
    rst = 1'b1;
    #1;
    chk("midop_reset_outputs", int'({Dados, Instrucao, busy, done, erro, resultado, contagem}), 0);
    chk("midop_reset_state", int'(state), 0);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", int'({done, erro, busy, state}), 0);
    end
    run_op(4, 4, 0, 3, 8, 0, 0, 1);
    chk("post_reset_done", r_done, 1);
    chk("post_reset_resultado", int'(resultado), 8);
    chk("post_reset_contagem", int'(contagem), 1);

    // start issued in the done cycle is accepted
    run_op(3, 2, 1, 2, 1, 0, 0, 0);
    chk("chain1_done", r_done, 1);
    run_op(10, 3, 2, 3, 20, 0, 0, 1);
    chk("chain2_ins_a", r_ind[0], 10);
    chk("chain2_ins_cyc", r_inc[0], 1);
    chk("chain2_done", r_done, 1);
    chk("chain2_resultado", int'(resultado), 20);
    chk("chain2_contagem", int'(contagem), 3);

    // 256 back-to-back operations wrap the counter
    rst = 1'b1; #2 rst = 1'b0;
    done_total = 0;
    for (int i = 0; i < 256; i++) begin
      run_op(i % 16, (i / 16) % 16, i % 4, 2, (i % 16) + ((i / 16) % 16), 0, 0, 0);
      done_total += r_done;
      if (i == 254) chk("wrap_at_255", int'(contagem), 255);
    end
    chk("wrap_done_total", done_total, 256);
    chk("wrap_contagem", int'(contagem), 0);
    chk("wrap_resultado", int'(resultado), 30);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/calc_sequenciador.md
Name: calc_sequenciador

Overview:
- Initiator-side driver for the calculator datapath's operand/instruction interface.
- Takes one complete operation request (opA, opB, opcode) through a start handshake.
- Plays it into the calculator as timed Dados/Instrucao steps, then waits for fim and captures saida_regC.
- Sits between the user/stimulus logic and the calculator top, replacing manual switch/button stimulus.

Parameters:
- GAP_CYCLES, 2: idle cycles with Instrucao=0 between consecutive instruction steps (minimum 1).
- TIMEOUT, 16: maximum cycles spent in WAIT_FIM before flagging erro (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- opA  input  4  operand A; latched on accepted start.
- opB  input  4  operand B; latched on accepted start.
- op  input  2  ULA opcode; latched on accepted start.
- fim  input  1  calculator result-valid flag.
- saida_regC  input  5  calculator result register.
- Dados  output  4  operand/opcode value presented to the calculator.
- Instrucao  output  1  step strobe to the calculator controller.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when resultado is updated.
- erro  output  1  one-cycle pulse on timeout.
- resultado  output  5  last captured saida_regC.
- contagem  output  8  count of successfully completed operations.
- state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (async, rst=1): state=IDLE(0); Dados=0, Instrucao=0, busy=0, done=0, erro=0, resultado=0, contagem=0; latched operands cleared; gap and timeout counters cleared.
- Reset mid-operation aborts immediately: no done, no erro, contagem unchanged from 0.
- FSM states and encodings:
  - IDLE=0, LOAD_A=1, GAP_A=2, LOAD_B=3, GAP_B=4, LOAD_OP=5, WAIT_FIM=6.
- All outputs are registered.
- IDLE:
  - start=1 latches opA/opB/op; next state LOAD_A.
  - start in any other state is ignored; there is no queueing.
- LOAD_A: exactly one cycle with Dados=latched opA, Instrucao=1; then GAP_A.
- GAP_A: Instrucao=0; Dados holds its previous value; lasts GAP_CYCLES cycles; then LOAD_B.
- LOAD_B: one cycle with Dados=opB, Instrucao=1; then GAP_B, identical in form to GAP_A.
- LOAD_OP: one cycle with Dados={2'b00,op}, Instrucao=1; then WAIT_FIM with the timeout counter cleared.
- WAIT_FIM: Instrucao=0. Each cycle:
  - If fim=1: resultado<=saida_regC, done=1 next cycle, contagem+1; next state IDLE.
  - Else timeout counter +1.
  - When the counter reaches TIMEOUT: erro=1 next cycle, resultado unchanged, contagem unchanged; next state IDLE.
- fim=1 on the same cycle the counter would expire: fim wins (result captured, no erro).
- fim asserted outside WAIT_FIM is ignored.
- contagem wraps 255 -> 0 without any flag.
- done and erro are never both high; each is high for exactly one cycle.
- start=1 in the cycle immediately after done/erro: the FSM is already in IDLE, so it is accepted.
- Latency with defaults, start accepted to first Instrucao: 1 cycle. Full sequence to WAIT_FIM entry: 1+1+2+1+2+1 = 8 cycles.

Test Plan:
- Reset check: rst pulse mid-LOAD_B -> all outputs 0 asynchronously (before next clk edge); state=0; subsequent start runs cleanly.
- Basic add: opA=5, opB=3, op=00; calculator model asserts fim 3 cycles after LOAD_OP with saida_regC=8 -> Instrucao pulses carry Dados 5, 3, 0 separated by 2 idle cycles; resultado=8; done pulses once; contagem=1.
- Overflow result: opA=15, opB=15, op=00; model returns 5'd30 -> resultado=30, full 5-bit value preserved.
- Timeout: model never asserts fim -> exactly 16 cycles in WAIT_FIM, erro pulses once, resultado holds its previous value, contagem unchanged, busy drops.
- Boundary collisions:
  - fim on the 16th wait cycle -> done, no erro.
  - start during busy -> ignored.
  - fim during GAP_A -> ignored.
- Wrap: 256 back-to-back successful operations -> contagem returns to 0; done count equals 256.
